mem_stage_data_access: RTL and testbench

- MEM-stage data-memory access unit. It sits between the EX/MEM pipeline barrier and the MEM/WB pipeline barrier.
- Converts a load/store held in EX/MEM into a req/ack transaction on the data-memory port. Performs byte-lane steering for stores and extraction plus sign/zero extension for loads.
- Stalls the pipeline until memory acknowledges. Delivers the load result on memMemoryData, which the MEM/WB barrier captures.

---
 rtl/mem_stage_data_access.sv | 151 +++++++++++++++
 tb/tb_mem_stage_data_access.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_data_access.sv
// MEM-stage data-memory access unit: turns an EX/MEM load/store into a req/ack
// transaction, steers store lanes, extends load data and stalls until done.
module mem_stage_data_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  memFunct3,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWdata,
    output logic [3:0]  dmemByteEn,
    input  logic [31:0] dmemRdata,
    input  logic        dmemAck,
    output logic [31:0] memMemoryData,
    output logic        memStall,
    output logic        memAccessFault,
    output logic        memTimeout,
    output logic [1:0]  fsm_state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]  state;
    logic [15:0] busy_count;
    logic [1:0]  lat_offset;
    logic [2:0]  lat_funct3;
    logic        access;
    logic        funct3_legal;
    logic        misaligned;
    logic        access_fault;
    logic        access_ok;
    logic        timed_out;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] shifted;
    logic [31:0] load_value;

    assign fsm_state = state;

    always_comb begin
        access = memRead | memWrite;
        funct3_legal = 1'b0;
        case (memFunct3)
            3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
            3'b100, 3'b101:         funct3_legal = ~memWrite;
            default:                funct3_legal = 1'b0;
        endcase
        misaligned = ((memFunct3[1:0] == 2'b01) & memAddress[0])
                   | ((memFunct3[1:0] == 2'b10) & (memAddress[1:0] != 2'b00));
        access_fault = access & ((memRead & memWrite) | ~funct3_legal | misaligned);
        access_ok = access & ~access_fault;
    end

    // Lane selection follows access size for loads too, so the memory sees
    // which bytes are actually being read.
    always_comb begin
        byte_en = 4'b1111;
        wdata = memWriteData;
        case (memFunct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << memAddress[1:0];
                wdata = {4{memWriteData[7:0]}};
            end
            2'b01: begin
                byte_en = memAddress[1] ? 4'b1100 : 4'b0011;
                wdata = {2{memWriteData[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata = memWriteData;
            end
        endcase
    end

    always_comb begin
        shifted = dmemRdata >> {lat_offset, 3'b000};
        case (lat_funct3)
            3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_value = {24'd0, shifted[7:0]};
            3'b101:  load_value = {16'd0, shifted[15:0]};
            default: load_value = dmemRdata;
        endcase
        timed_out = (busy_count + 16'd1) == TIMEOUT_LIMIT;
    end

    assign memStall = ~reset & (((state == IDLE) & access_ok) | (state == BUSY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy_count     <= 16'd0;
            lat_offset     <= 2'd0;
            lat_funct3     <= 3'd0;
            dmemReq        <= 1'b0;
            dmemWe         <= 1'b0;
            dmemAddr       <= 32'd0;
            dmemWdata      <= 32'd0;
            dmemByteEn     <= 4'd0;
            memMemoryData  <= 32'd0;
            memAccessFault <= 1'b0;
            memTimeout     <= 1'b0;
        end else begin
            memAccessFault <= 1'b0;
            memTimeout     <= 1'b0;
            case (state)
                IDLE: begin
                    if (access_ok) begin
                        state      <= BUSY;
                        busy_count <= 16'd0;
                        lat_offset <= memAddress[1:0];
                        lat_funct3 <= memFunct3;
                        dmemReq    <= 1'b1;
                        dmemWe     <= memWrite;
                        dmemAddr   <= {memAddress[31:2], 2'b00};
                        dmemWdata  <= wdata;
                        dmemByteEn <= byte_en;
                    end else if (access_fault) begin
                        memAccessFault <= 1'b1;
                        memMemoryData  <= 32'd0;
                    end
                end
                BUSY: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (dmemAck) begin
                        dmemReq       <= 1'b0;
                        memMemoryData <= dmemWe ? 32'd0 : load_value;
                        state         <= DONE;
                    end else if (timed_out) begin
                        dmemReq       <= 1'b0;
                        memMemoryData <= 32'd0;
                        memTimeout    <= 1'b1;
                        state         <= DONE;
                    end else begin
                        busy_count <= busy_count + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_data_access.sv
// Bench for mem_stage_data_access: directed scenarios plus randomized accesses
// checked against an arithmetic model of the load/store rules.
module tb_mem_stage_data_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] memAddress = '0;
    logic [31:0] memWriteData = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  memFunct3 = '0;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemByteEn;
    logic [31:0] dmemRdata = '0;
    logic        dmemAck = 1'b0;
    logic [31:0] memMemoryData;
    logic        memStall;
    logic        memAccessFault;
    logic        memTimeout;
    logic [1:0]  fsm_state;

    int tests_run = 0;
    int tests_failed = 0;
    int last_stalls = 0;
    logic [31:0] last_data = '0;

    always #5 clk = ~clk;

    mem_stage_data_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memRead(memRead), .memWrite(memWrite), .memFunct3(memFunct3),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
        .dmemWdata(dmemWdata), .dmemByteEn(dmemByteEn),
        .dmemRdata(dmemRdata), .dmemAck(dmemAck),
        .memMemoryData(memMemoryData), .memStall(memStall),
        .memAccessFault(memAccessFault), .memTimeout(memTimeout),
        .fsm_state(fsm_state)
    );

    function automatic bit model_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] addr);
        int size;
        if (rd && wr) return 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        size = 1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        int off;
        off = int'(addr % 4);
        v = rdata >> (8 * off);
        case (f3)
            3'd0: begin v = v & 32'hFF; if (v >= 128) v = v - 256; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 65536; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int size;
        int off;
        size = 1 << f3[1:0];
        off = int'(addr % 4);
        if (size == 4) return 4'hF;
        if (size == 2) return (off >= 2) ? 4'hC : 4'h3;
        return 4'(1 << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_delay, input logic [31:0] rdata,
                             input bit scramble);
        bit fault;
        bit exp_to;
        int busy;
        int exp_busy;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        fault = model_fault(rd, wr, f3, addr);
        @(negedge clk);
        memRead = rd; memWrite = wr; memFunct3 = f3;
        memAddress = addr; memWriteData = wd; dmemAck = 1'b0;
        #1;
        tests_run++;
        if (memStall !== !fault)
            $display("FAIL idle_stall: got %b expected %b (addr %h f3 %0d)", memStall, !fault, addr, f3);
        if (memStall !== !fault) tests_failed++;
        @(negedge clk);
        if (fault) begin
            tests_run++;
            if (memAccessFault !== 1'b1 || dmemReq !== 1'b0 || memStall !== 1'b0 || memMemoryData !== 32'd0) begin
                tests_failed++;
                $display("FAIL fault_resp: fault=%b req=%b stall=%b data=%h expected 1 0 0 0", memAccessFault, dmemReq, memStall, memMemoryData);
            end
            last_data = 32'd0;
            memRead = 1'b0; memWrite = 1'b0;
            @(negedge clk);
            tests_run++;
            if (memAccessFault !== 1'b0 || dmemReq !== 1'b0) begin
                tests_failed++;
                $display("FAIL fault_pulse: fault=%b req=%b expected 0 0", memAccessFault, dmemReq);
            end
            last_stalls = 0;
            return;
        end
        exp_addr = addr & ~32'h3;
        exp_be = model_be(f3, addr);
        exp_wd = model_wdata(f3, wd);
        exp_to = !(ack_delay > 0 && ack_delay <= TO);
        exp_busy = exp_to ? TO : ack_delay;
        exp_data = (exp_to || wr) ? 32'd0 : model_load(f3, addr, rdata);
        busy = 0;
        while (memStall === 1'b1 && busy < 100) begin
            tests_run++;
            if (dmemReq !== 1'b1 || dmemWe !== wr || dmemAddr !== exp_addr || dmemByteEn !== exp_be
                || (wr && dmemWdata !== exp_wd)) begin
                tests_failed++;
                $display("FAIL request: req=%b we=%b addr=%h be=%b wdata=%h expected 1 %b %h %b %h",
                         dmemReq, dmemWe, dmemAddr, dmemByteEn, dmemWdata, wr, exp_addr, exp_be, exp_wd);
            end
            busy++;
            if (scramble) begin
                memAddress = $urandom; memWriteData = $urandom;
                memFunct3 = 3'($urandom_range(7, 0));
            end
            if (busy == ack_delay) begin
                dmemAck = 1'b1; dmemRdata = rdata;
            end else begin
                dmemAck = 1'b0; dmemRdata = $urandom;
            end
            @(negedge clk);
        end
        dmemAck = 1'b0;
        last_stalls = 1 + busy;
        tests_run++;
        if (busy != exp_busy) begin
            tests_failed++;
            $display("FAIL busy_cycles: got %0d expected %0d", busy, exp_busy);
        end
        tests_run++;
        if (memMemoryData !== exp_data) begin
            tests_failed++;
            $display("FAIL load_data: got %h expected %h (f3 %0d addr %h rdata %h)", memMemoryData, exp_data, f3, addr, rdata);
        end
        tests_run++;
        if (memTimeout !== exp_to || dmemReq !== 1'b0 || memStall !== 1'b0 || memAccessFault !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_state: timeout=%b req=%b stall=%b fault=%b expected %b 0 0 0", memTimeout, dmemReq, memStall, memAccessFault, exp_to);
        end
        last_data = exp_data;
        @(posedge clk);
        #1;
        tests_run++;
        if (dmemReq !== 1'b0 || memTimeout !== 1'b0 || memMemoryData !== exp_data) begin
            tests_failed++;
            $display("FAIL no_reissue: req=%b timeout=%b data=%h expected 0 0 %h", dmemReq, memTimeout, memMemoryData, exp_data);
        end
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        memRead = 1'b1; memFunct3 = 3'd2; memAddress = 32'h100;
        repeat (2) @(negedge clk);
        tests_run++;
        if (dmemReq !== 1'b0 || dmemWe !== 1'b0 || dmemAddr !== 32'd0 || dmemWdata !== 32'd0 || dmemByteEn !== 4'd0
            || memMemoryData !== 32'd0 || memStall !== 1'b0 || memAccessFault !== 1'b0 || memTimeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: req=%b addr=%h be=%b data=%h stall=%b expected all zero", dmemReq, dmemAddr, dmemByteEn, memMemoryData, memStall);
        end
        memRead = 1'b0;
        reset = 1'b0;
        last_data = 32'd0;
    endtask

    task automatic test_lw();
        do_access(1, 0, 3'd2, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0);
        tests_run++;
        if (last_stalls != 3 || memMemoryData !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL lw_basic: stalls=%0d data=%h expected 3 deadbeef", last_stalls, memMemoryData);
        end
    endtask

    task automatic test_byte_loads();
        do_access(1, 0, 3'd0, 32'h203, 32'h0, 1, 32'h80FF_0000, 0);
        tests_run++;
        if (memMemoryData !== 32'hFFFFFF80) begin
            tests_failed++;
            $display("FAIL lb_sign: got %h expected ffffff80", memMemoryData);
        end
        do_access(1, 0, 3'd4, 32'h203, 32'h0, 1, 32'h80FF_0000, 0);
        tests_run++;
        if (memMemoryData !== 32'h00000080) begin
            tests_failed++;
            $display("FAIL lbu_zero: got %h expected 00000080", memMemoryData);
        end
        do_access(1, 0, 3'd1, 32'h202, 32'h0, 3, 32'h9ABC_1234, 0);
        do_access(1, 0, 3'd5, 32'h202, 32'h0, 1, 32'h9ABC_1234, 0);
    endtask

    task automatic test_store();
        do_access(0, 1, 3'd1, 32'h42, 32'h1234ABCD, 1, 32'hFFFF_FFFF, 0);
        do_access(0, 1, 3'd0, 32'h41, 32'h0000_00A5, 2, 32'h0, 1);
        do_access(0, 1, 3'd2, 32'h44, 32'hCAFE_F00D, 1, 32'h0, 1);
    endtask

    task automatic test_faults();
        do_access(1, 0, 3'd2, 32'h102, 32'h0, 1, 32'h0, 0);
        do_access(1, 1, 3'd2, 32'h100, 32'h0, 1, 32'h0, 0);
        do_access(0, 1, 3'd4, 32'h100, 32'h0, 1, 32'h0, 0);
        do_access(1, 0, 3'd1, 32'h101, 32'h0, 1, 32'h0, 0);
    endtask

    task automatic test_timeout();
        do_access(1, 0, 3'd2, 32'h300, 32'h0, 0, 32'h0, 0);
        tests_run++;
        if (last_stalls != 1 + TO || memMemoryData !== 32'd0) begin
            tests_failed++;
            $display("FAIL timeout_len: stalls=%0d data=%h expected %0d 0", last_stalls, memMemoryData, 1 + TO);
        end
        do_access(1, 0, 3'd2, 32'h304, 32'h0, TO, 32'h1357_9BDF, 0);
        do_access(1, 0, 3'd2, 32'h308, 32'h0, TO + 1, 32'h1357_9BDF, 0);
    endtask

    task automatic test_idle_hold();
        do_access(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h5A5A_0F0F, 0);
        repeat (3) begin
            @(negedge clk);
            dmemAck = 1'b1; dmemRdata = $urandom;
        end
        @(negedge clk);
        dmemAck = 1'b0;
        tests_run++;
        if (memMemoryData !== last_data || dmemReq !== 1'b0 || memStall !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: data=%h req=%b stall=%b expected %h 0 0", memMemoryData, dmemReq, memStall, last_data);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        memRead = 1'b1; memFunct3 = 3'd2; memAddress = 32'h100;
        @(negedge clk);
        tests_run++;
        if (dmemReq !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_entry: req=%b expected 1", dmemReq);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (dmemReq !== 1'b0 || memStall !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: req=%b stall=%b expected 0 0", dmemReq, memStall);
        end
        memRead = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_data = 32'd0;
        do_access(1, 0, 3'd2, 32'h100, 32'h0, 1, 32'h0BAD_F00D, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int sel;
            bit rd;
            bit wr;
            logic [2:0] f3;
            sel = $urandom_range(0, 9);
            rd = (sel < 5) || (sel == 9);
            wr = (sel >= 5);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(7, 0))
                                             : (wr ? 3'($urandom_range(2, 0)) : 3'($urandom_range(5, 0)));
            do_access(rd, wr, f3, $urandom, $urandom, $urandom_range(0, TO + 2), $urandom,
                      1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_byte_loads();
        test_store();
        test_faults();
        test_timeout();
        test_idle_hold();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
